pipe_bpred: RTL and testbench
=============================

# pipe_bpred

Dynamic branch and return predictor for the Y86-64 pipeline; replaces the always-taken next-PC predictor in fetch. It predicts conditional jumps from a table of saturating counters indexed by PC or by PC XOR global history, predicts `ret` targets from a return-address stack, and is trained from execute. Mispredict recovery uses a checkpoint that travels down the pipeline with each instruction.

## Interface
- `ENTRIES`, 64: counter-table depth; power of 2; `IDX_W` = log2(ENTRIES).
- `CTR_W`, 2: counter width, 1..4.
- `MODE`, 1: 0 = always-taken; 1 = bimodal; 2 = gshare, with a global history register of `IDX_W` bits.
- `RAS_DEPTH`, 8: return-stack entries; power of 2; `P_W` = log2(RAS_DEPTH).
- `CK_W`: derived, = `IDX_W` + `P_W` + `P_W` + 1; checkpoint layout is {ghr, ras_ptr, ras_cnt}.
- `clk` in 1: the single clock; every state update happens on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `f_valid` in 1: the fetched instruction advances F->D this cycle (not stalled, not bubbled).
- `f_pc`, `f_valC`, `f_valP` in 64 each: fetch PC, constant word and incremented PC.
- `f_icode`, `f_ifun` in 4 each: fetched instruction code and function.
- `f_predPC` out 64: predicted next PC.
- `f_pred_taken` out 1: prediction bit; the pipeline carries it to E as `E_pred_taken`.
- `f_ret_hit` out 1: a `ret` was predicted from the RAS. When low for a `ret`, the pipeline stalls for `ret` as before.
- `f_ckpt` out `CK_W`: snapshot taken before this instruction's speculative update; the pipeline carries it to E as `E_ckpt`.
- `E_valid` in 1: E holds a real instruction, not a bubble.
- `E_icode`, `E_ifun` in 4 each: instruction code and function in E.
- `E_pc` in 64: PC of the instruction in E.
- `E_pred_taken` in 1: prediction bit carried from fetch.
- `E_ckpt` in `CK_W`: checkpoint carried from fetch.
- `e_Cnd` in 1: condition outcome computed in execute.
- `e_mispred` out 1: combinational mispredict flag for the pipeline control logic.

## Operation
- Counter read is combinational from `f_pc`.
  - `idx` = `f_pc[IDX_W-1:0]` in MODE 1.
  - `idx` = `f_pc[IDX_W-1:0]` ^ ghr in MODE 2.
  - Predict taken when the counter MSB is 1; MODE 0 always predicts taken.
- Next-PC selection:
  - jXX with `ifun`=0 (jmp) or `call` (icode 8): `f_predPC` = `f_valC`, `f_pred_taken` = 1.
  - jXX with `ifun`≠0: `f_predPC` = taken ? `f_valC` : `f_valP`.
  - `ret` (icode 9) with `ras_cnt` > 0: `f_predPC` = top of stack, `f_ret_hit` = 1.
  - `ret` with `ras_cnt` = 0: `f_predPC` = `f_valP`, `f_ret_hit` = 0.
  - Any other instruction: `f_predPC` = `f_valP`, `f_pred_taken` = 0.
- Speculative updates apply only when `f_valid`=1.
  - Conditional jXX in MODE 2: ghr <= {ghr[IDX_W-2:0], predicted bit}.
  - `call`: write `f_valP` at `ras_ptr`, then `ras_ptr` + 1. `ras_cnt` saturates at `RAS_DEPTH`. On overflow the pointer wraps and the oldest entry is overwritten.
  - `ret` with a hit: `ras_ptr` − 1, `ras_cnt` − 1.
- Resolve: `upd` = `E_valid` & `E_icode`==7 & `E_ifun`≠0.
  - `e_mispred` = `upd` & (`E_pred_taken` ≠ `e_Cnd`).
  - Train the counter at the index recomputed from `E_pc` and the `E_ckpt` ghr. Increment when `e_Cnd`=1, decrement otherwise, saturating at 0 and 2^CTR_W−1.
  - MODE 0 performs no training.
- Recovery on `e_mispred`:
  - ghr <= {`E_ckpt`.ghr[IDX_W-2:0], `e_Cnd`}.
  - `ras_ptr` and `ras_cnt` <= `E_ckpt` values. RAS contents are not restored.
  - Recovery overrides any speculative update from fetch in the same cycle.
- Reset values:
  - All counters = 2^(CTR_W−1) (weakly taken); ghr = 0; `ras_ptr` = 0; `ras_cnt` = 0.
  - All outputs are combinational functions of this state and the inputs. After reset, a conditional jXX predicts `f_valC`.

## Timing
- Prediction has zero latency: `f_predPC` is valid in the same cycle as `f_pc`.
- Training and recovery take effect at the rising edge where `upd`/`e_mispred` is high. They are visible to fetch in the next cycle.
- Read-during-write to the same counter index: fetch sees the old value.
- `call` push and a same-cycle recovery: recovery wins; the pushed data word may still be written.
- `rst` asserted mid-operation: all state returns to reset values at that edge. `e_mispred` keeps its combinational value during reset.

## Test plan
- Reset, MODE 1, CTR_W 2; jne at PC 0x40 resolved not-taken twice -> first `e_mispred`=1; counter 2->1->0; third fetch `f_predPC` = `f_valP`, `f_pred_taken`=0.
- Same branch resolved taken four times after saturating at 0 -> counter reaches 3 and stays at 3 on a fifth taken; predictions flip to taken after the second taken.
- `call` at 0x100 (`valP` 0x109), then `ret` -> `f_ret_hit`=1, `f_predPC`=0x109; second `ret` on empty stack -> `f_ret_hit`=0.
- RAS_DEPTH 4, five nested calls -> `ras_cnt` stays 4; four `ret`s return the newest four `valP`s in reverse order.
- MODE 2: mispredicted branch with `E_ckpt` ghr=0b0101, `e_Cnd`=1, plus a same-cycle fetch of a jXX -> ghr = 0b1011 (the 6-bit value with low bits 001011), fetch update ignored; `ras_ptr` restored.
- MODE 0: 100 random jXX outcomes -> always predicted taken, counters untouched, `e_mispred` = ¬`e_Cnd`.

Source files
------------

// File: rtl/pipe_bpred.sv
// Y86-64 fetch predictor: saturating-counter table (bimodal or gshare) plus a return-address stack.
// Execute trains the counters and, on a mispredict, restores history and stack pointers from the carried checkpoint.
module pipe_bpred #(
    parameter int ENTRIES   = 64,
    parameter int CTR_W     = 2,
    parameter int MODE      = 1,
    parameter int RAS_DEPTH = 8,
    localparam int IDX_W    = $clog2(ENTRIES),
    localparam int P_W      = $clog2(RAS_DEPTH),
    localparam int CK_W     = IDX_W + P_W + P_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_valid,
    input  logic [63:0]       f_pc,
    input  logic [63:0]       f_valC,
    input  logic [63:0]       f_valP,
    input  logic [3:0]        f_icode,
    input  logic [3:0]        f_ifun,
    output logic [63:0]       f_predPC,
    output logic              f_pred_taken,
    output logic              f_ret_hit,
    output logic [CK_W-1:0]   f_ckpt,
    input  logic              E_valid,
    input  logic [3:0]        E_icode,
    input  logic [3:0]        E_ifun,
    input  logic [63:0]       E_pc,
    input  logic              E_pred_taken,
    input  logic [CK_W-1:0]   E_ckpt,
    input  logic              e_Cnd,
    output logic              e_mispred
);

    localparam int CNT_W = P_W + 1;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RAS_DEPTH);

    localparam logic [3:0] IC_JXX  = 4'h7;
    localparam logic [3:0] IC_CALL = 4'h8;
    localparam logic [3:0] IC_RET  = 4'h9;

    logic [CTR_W-1:0] r_ctr [ENTRIES];
    logic [IDX_W-1:0] r_ghr;
    logic [P_W-1:0]   r_ras_ptr;
    logic [CNT_W-1:0] r_ras_cnt;
    logic [63:0]      r_ras [RAS_DEPTH];

    logic             w_f_cjmp;
    logic             w_f_ujmp;
    logic             w_f_call;
    logic             w_f_ret;
    logic             w_ras_nonempty;
    logic [IDX_W-1:0] w_f_idx;
    logic [CTR_W-1:0] w_f_ctr;
    logic             w_f_taken;
    logic [P_W-1:0]   w_top_ptr;
    logic [63:0]      w_ras_top;

    logic [IDX_W-1:0] w_e_ghr;
    logic [P_W-1:0]   w_e_ptr;
    logic [CNT_W-1:0] w_e_cnt;
    logic             w_upd;
    logic [IDX_W-1:0] w_e_idx;
    logic [CTR_W-1:0] w_e_ctr;

    logic [IDX_W-1:0] w_ghr_nxt;
    logic [P_W-1:0]   w_ptr_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_unused;

    assign w_unused = ^{f_pc[63:IDX_W], E_pc[63:IDX_W]};

    // Fetch-side decode and prediction
    assign w_f_cjmp       = (f_icode == IC_JXX) && (f_ifun != 4'h0);
    assign w_f_ujmp       = ((f_icode == IC_JXX) && (f_ifun == 4'h0)) || (f_icode == IC_CALL);
    assign w_f_call       = (f_icode == IC_CALL);
    assign w_f_ret        = (f_icode == IC_RET);
    assign w_ras_nonempty = (r_ras_cnt != '0);
    assign w_f_idx        = f_pc[IDX_W-1:0] ^ ((MODE == 2) ? r_ghr : '0);
    assign w_f_ctr        = r_ctr[w_f_idx];
    assign w_f_taken      = (MODE == 0) ? 1'b1 : w_f_ctr[CTR_W-1];
    assign w_top_ptr      = r_ras_ptr - P_W'(1);
    assign w_ras_top      = r_ras[w_top_ptr];

    always_comb begin
        f_predPC     = f_valP;
        f_pred_taken = 1'b0;
        f_ret_hit    = 1'b0;
        if (w_f_ujmp) begin
            f_predPC     = f_valC;
            f_pred_taken = 1'b1;
        end else if (w_f_cjmp) begin
            f_pred_taken = w_f_taken;
            f_predPC     = w_f_taken ? f_valC : f_valP;
        end else if (w_f_ret && w_ras_nonempty) begin
            f_predPC  = w_ras_top;
            f_ret_hit = 1'b1;
        end
    end

    assign f_ckpt = {r_ghr, r_ras_ptr, r_ras_cnt};

    // Execute-side resolve
    assign w_e_ghr   = E_ckpt[CK_W-1 -: IDX_W];
    assign w_e_ptr   = E_ckpt[CNT_W +: P_W];
    assign w_e_cnt   = E_ckpt[CNT_W-1:0];
    assign w_upd     = E_valid && (E_icode == IC_JXX) && (E_ifun != 4'h0);
    assign e_mispred = w_upd && (E_pred_taken != e_Cnd);
    assign w_e_idx   = E_pc[IDX_W-1:0] ^ ((MODE == 2) ? w_e_ghr : '0);
    assign w_e_ctr   = r_ctr[w_e_idx];

    // Recovery has priority over any speculative fetch update in the same cycle
    always_comb begin
        w_ghr_nxt = r_ghr;
        w_ptr_nxt = r_ras_ptr;
        w_cnt_nxt = r_ras_cnt;
        if (e_mispred) begin
            if (MODE == 2) begin
                w_ghr_nxt = {w_e_ghr[IDX_W-2:0], e_Cnd};
            end
            w_ptr_nxt = w_e_ptr;
            w_cnt_nxt = w_e_cnt;
        end else if (f_valid) begin
            if (w_f_cjmp && (MODE == 2)) begin
                w_ghr_nxt = {r_ghr[IDX_W-2:0], w_f_taken};
            end
            if (w_f_call) begin
                w_ptr_nxt = r_ras_ptr + P_W'(1);
                w_cnt_nxt = (r_ras_cnt == CNT_MAX) ? r_ras_cnt : r_ras_cnt + CNT_W'(1);
            end else if (w_f_ret && w_ras_nonempty) begin
                w_ptr_nxt = r_ras_ptr - P_W'(1);
                w_cnt_nxt = r_ras_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= CTR_INIT;
            end
            r_ghr     <= '0;
            r_ras_ptr <= '0;
            r_ras_cnt <= '0;
        end else begin
            r_ghr     <= w_ghr_nxt;
            r_ras_ptr <= w_ptr_nxt;
            r_ras_cnt <= w_cnt_nxt;
            if (w_upd && (MODE != 0)) begin
                if (e_Cnd) begin
                    if (w_e_ctr != CTR_MAX) r_ctr[w_e_idx] <= w_e_ctr + CTR_W'(1);
                end else begin
                    if (w_e_ctr != '0) r_ctr[w_e_idx] <= w_e_ctr - CTR_W'(1);
                end
            end
        end
    end

    // Stack contents are never reset or restored; only the pointer and count are checkpointed
    always_ff @(posedge clk) begin
        if (!rst && f_valid && w_f_call) begin
            r_ras[r_ras_ptr] <= f_valP;
        end
    end

endmodule

// File: tb/tb_pipe_bpred.sv
// Directed bench for pipe_bpred: one bimodal, one gshare and one always-taken instance share the stimulus.
module tb_pipe_bpred;

    localparam int IDX_W = 6;
    localparam int P_W   = 2;
    localparam int CK_W  = IDX_W + P_W + P_W + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            f_valid;
    logic [63:0]     f_pc, f_valC, f_valP;
    logic [3:0]      f_icode, f_ifun;
    logic            E_valid;
    logic [3:0]      E_icode, E_ifun;
    logic [63:0]     E_pc;
    logic            E_pred_taken;
    logic [CK_W-1:0] E_ckpt;
    logic            e_Cnd;

    logic [63:0]     b_predPC, g_predPC, t_predPC;
    logic            b_taken, g_taken, t_taken;
    logic            b_hit, g_hit, t_hit;
    logic [CK_W-1:0] b_ckpt, g_ckpt, t_ckpt;
    logic            b_mis, g_mis, t_mis;

    pipe_bpred #(.ENTRIES(64), .CTR_W(2), .MODE(1), .RAS_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .f_valid(f_valid), .f_pc(f_pc), .f_valC(f_valC), .f_valP(f_valP),
        .f_icode(f_icode), .f_ifun(f_ifun), .f_predPC(b_predPC), .f_pred_taken(b_taken),
        .f_ret_hit(b_hit), .f_ckpt(b_ckpt), .E_valid(E_valid), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_pc(E_pc), .E_pred_taken(E_pred_taken), .E_ckpt(E_ckpt), .e_Cnd(e_Cnd), .e_mispred(b_mis));

    pipe_bpred #(.ENTRIES(64), .CTR_W(2), .MODE(2), .RAS_DEPTH(4)) dut_g (
        .clk(clk), .rst(rst), .f_valid(f_valid), .f_pc(f_pc), .f_valC(f_valC), .f_valP(f_valP),
        .f_icode(f_icode), .f_ifun(f_ifun), .f_predPC(g_predPC), .f_pred_taken(g_taken),
        .f_ret_hit(g_hit), .f_ckpt(g_ckpt), .E_valid(E_valid), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_pc(E_pc), .E_pred_taken(E_pred_taken), .E_ckpt(E_ckpt), .e_Cnd(e_Cnd), .e_mispred(g_mis));

    pipe_bpred #(.ENTRIES(64), .CTR_W(2), .MODE(0), .RAS_DEPTH(4)) dut_t (
        .clk(clk), .rst(rst), .f_valid(f_valid), .f_pc(f_pc), .f_valC(f_valC), .f_valP(f_valP),
        .f_icode(f_icode), .f_ifun(f_ifun), .f_predPC(t_predPC), .f_pred_taken(t_taken),
        .f_ret_hit(t_hit), .f_ckpt(t_ckpt), .E_valid(E_valid), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_pc(E_pc), .E_pred_taken(E_pred_taken), .E_ckpt(E_ckpt), .e_Cnd(e_Cnd), .e_mispred(t_mis));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        f_valid = 1'b0; f_pc = '0; f_valC = '0; f_valP = '0; f_icode = 4'h1; f_ifun = 4'h0;
        E_valid = 1'b0; E_icode = 4'h0; E_ifun = 4'h0; E_pc = '0; E_pred_taken = 1'b0;
        E_ckpt = '0; e_Cnd = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_fetch(input logic [63:0] pc, input logic [3:0] ic, input logic [3:0] fn,
                             input logic [63:0] vc, input logic [63:0] vp, input logic vld);
        f_pc = pc; f_icode = ic; f_ifun = fn; f_valC = vc; f_valP = vp; f_valid = vld;
    endtask

    task automatic set_exec(input logic [63:0] pc, input logic pred, input logic cnd,
                            input logic [CK_W-1:0] ck);
        E_valid = 1'b1; E_icode = 4'h7; E_ifun = 4'h4; E_pc = pc;
        E_pred_taken = pred; e_Cnd = cnd; E_ckpt = ck;
    endtask

    // Fetch the jne at 0x40 (valC 0x200, valP 0x49) without advancing and check the bimodal prediction
    task automatic b_pred(input string tag, input logic exp_taken);
        set_fetch(64'h40, 4'h7, 4'h4, 64'h200, 64'h49, 1'b0);
        settle();
        check({tag, "_pc"}, b_predPC, exp_taken ? 64'h200 : 64'h49);
        check({tag, "_tk"}, {63'd0, b_taken}, {63'd0, exp_taken});
    endtask

    task automatic b_resolve(input string tag, input logic pred, input logic cnd);
        set_exec(64'h40, pred, cnd, '0);
        settle();
        check({tag, "_mis"}, {63'd0, b_mis}, {63'd0, pred != cnd});
        tick();
        E_valid = 1'b0;
    endtask

    initial begin
        logic [63:0] pc, vc, vp;
        logic        cnd;
        logic [3:0]  fn;

        do_reset();

        // Reset state and basic next-PC selection
        check("rst_ckpt", {53'd0, b_ckpt}, 64'd0);
        b_pred("rst_jne", 1'b1);
        set_fetch(64'h50, 4'h6, 4'h0, 64'h0, 64'h52, 1'b0);
        settle();
        check("op_pc", b_predPC, 64'h52);
        check("op_tk", {63'd0, b_taken}, 64'd0);
        set_fetch(64'h60, 4'h7, 4'h0, 64'h700, 64'h69, 1'b0);
        settle();
        check("jmp_pc", b_predPC, 64'h700);
        check("jmp_tk", {63'd0, b_taken}, 64'd1);

        // Bimodal training: 2 -> 1 -> 0 -> 0 (saturate), then climb to 3 and hold
        b_resolve("nt1", 1'b1, 1'b0);  b_pred("after_nt1", 1'b0);
        b_resolve("nt2", 1'b0, 1'b0);  b_pred("after_nt2", 1'b0);
        b_resolve("nt3", 1'b0, 1'b0);  b_pred("after_nt3", 1'b0);
        set_fetch(64'h41, 4'h7, 4'h4, 64'h200, 64'h4a, 1'b0);
        settle();
        check("other_idx", b_predPC, 64'h200);
        b_resolve("t1", 1'b0, 1'b1);   b_pred("after_t1", 1'b0);
        b_resolve("t2", 1'b0, 1'b1);   b_pred("after_t2", 1'b1);
        b_resolve("t3", 1'b1, 1'b1);   b_pred("after_t3", 1'b1);
        b_resolve("t4", 1'b1, 1'b1);   b_pred("after_t4", 1'b1);
        b_resolve("t5", 1'b1, 1'b1);   b_pred("after_t5", 1'b1);
        b_resolve("dn1", 1'b1, 1'b0);  b_pred("after_dn1", 1'b1);

        // Read-during-write: same-cycle fetch sees the old counter (2), next cycle sees 1
        set_exec(64'h40, 1'b1, 1'b0, '0);
        b_pred("rdw_old", 1'b1);
        tick();
        E_valid = 1'b0;
        b_pred("rdw_new", 1'b0);

        // Reset mid-operation: mispredict stays visible, table returns to weakly taken
        set_exec(64'h40, 1'b1, 1'b0, '0);
        rst = 1'b1;
        settle();
        check("rst_mis", {63'd0, b_mis}, 64'd1);
        tick();
        rst = 1'b0;
        idle();
        b_pred("post_rst", 1'b1);

        // call at 0x100 then ret, then ret on an empty stack
        do_reset();
        set_fetch(64'h100, 4'h8, 4'h0, 64'h300, 64'h109, 1'b1);
        settle();
        check("call_pc", b_predPC, 64'h300);
        check("call_tk", {63'd0, b_taken}, 64'd1);
        tick();
        check("call_ck", {53'd0, b_ckpt}, {53'd0, 6'd0, 2'd1, 3'd1});
        set_fetch(64'h300, 4'h9, 4'h0, 64'h0, 64'h301, 1'b1);
        settle();
        check("ret_hit", {63'd0, b_hit}, 64'd1);
        check("ret_pc", b_predPC, 64'h109);
        tick();
        settle();
        check("ret2_hit", {63'd0, b_hit}, 64'd0);
        check("ret2_pc", b_predPC, 64'h301);
        tick();
        check("ret2_ck", {53'd0, b_ckpt}, 64'd0);

        // Five nested calls into a 4-deep stack: count saturates, newest four come back
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_fetch(64'h800 + 64'(i), 4'h8, 4'h0, 64'h900, 64'h1000 + 64'(16 * i), 1'b1);
            tick();
        end
        check("ovf_ck", {53'd0, b_ckpt}, {53'd0, 6'd0, 2'd1, 3'd4});
        for (int k = 0; k < 4; k++) begin
            set_fetch(64'ha00, 4'h9, 4'h0, 64'h0, 64'ha01, 1'b1);
            settle();
            check($sformatf("nest_hit%0d", k), {63'd0, b_hit}, 64'd1);
            check($sformatf("nest_pc%0d", k), b_predPC, 64'h1040 - 64'(16 * k));
            tick();
        end
        settle();
        check("nest_empty", {63'd0, b_hit}, 64'd0);

        // gshare: history shift, recovery priority, history-indexed lookup
        do_reset();
        set_fetch(64'h40, 4'h7, 4'h4, 64'h200, 64'h49, 1'b1);
        settle();
        check("gs_tk", {63'd0, g_taken}, 64'd1);
        tick();
        check("gs_ghr1", {53'd0, g_ckpt}, {53'd0, 6'b000001, 2'd0, 3'd0});
        set_fetch(64'h100, 4'h8, 4'h0, 64'h300, 64'h109, 1'b1);
        tick();
        check("gs_call", {53'd0, g_ckpt}, {53'd0, 6'b000001, 2'd1, 3'd1});
        set_fetch(64'h40, 4'h7, 4'h4, 64'h200, 64'h49, 1'b1);
        set_exec(64'h80, 1'b0, 1'b1, {6'b000101, 2'd0, 3'd0});
        settle();
        check("gs_mis", {63'd0, g_mis}, 64'd1);
        tick();
        idle();
        check("gs_recov", {53'd0, g_ckpt}, {53'd0, 6'b001011, 2'd0, 3'd0});
        for (int k = 0; k < 2; k++) begin
            set_exec(64'h0b, 1'b0, 1'b0, '0);
            tick();
        end
        idle();
        check("gs_ghr_kept", {53'd0, g_ckpt}, {53'd0, 6'b001011, 2'd0, 3'd0});
        set_fetch(64'h00, 4'h7, 4'h2, 64'h200, 64'h09, 1'b0);
        settle();
        check("gs_idx11_pc", g_predPC, 64'h09);
        check("gs_idx11_tk", {63'd0, g_taken}, 64'd0);
        set_fetch(64'h0b, 4'h7, 4'h2, 64'h200, 64'h14, 1'b0);
        settle();
        check("gs_idx0_pc", g_predPC, 64'h200);

        // Always-taken mode under random outcomes
        do_reset();
        for (int i = 0; i < 100; i++) begin
            pc  = {$urandom, $urandom};
            vc  = {$urandom, $urandom};
            vp  = pc + 64'd9;
            fn  = 4'($urandom_range(1, 6));
            cnd = 1'($urandom_range(0, 1));
            set_fetch(pc, 4'h7, fn, vc, vp, 1'b1);
            set_exec(pc, 1'b1, cnd, '0);
            settle();
            check($sformatf("m0_tk%0d", i), {63'd0, t_taken}, 64'd1);
            check($sformatf("m0_pc%0d", i), t_predPC, vc);
            check($sformatf("m0_mis%0d", i), {63'd0, t_mis}, {63'd0, ~cnd});
            tick();
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
